// File: rtl/sp_ram_bidir_pkg.sv
// Shared constants, types and operation decode for the 16x8 bidirectional-bus RAM.
package sp_ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Encodings line up with the {we, enable} pair so the decode is a plain cast
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    WRITE   = 2'b10,
    ILLEGAL = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic we, input logic enable);
    return op_e'({we, enable});
  endfunction

endpackage

// File: rtl/sp_ram_bidir_if.sv
// Control bundle for the RAM: write enable, read enable and word address.
interface sp_ram_bidir_if;
  import sp_ram_pkg::*;

  logic  we;
  logic  enable;
  addr_t addr;

  modport master (output we, output enable, output addr);
  modport slave  (input  we, input  enable, input  addr);

endinterface

// File: rtl/sp_ram_bidir_tribuf.sv
// DATA_W-wide tri-state pad driver: drives the pad only while i_oe is high.
module sp_ram_tribuf
  import sp_ram_pkg::*;
(
  input  word_t             i_data,
  input  logic              i_oe,
  inout  wire  [DATA_W-1:0] io_pad
);

  assign io_pad = i_oe ? i_data : {DATA_W{1'bz}};

endmodule

// File: rtl/sp_ram_bidir.sv
// 16x8 RAM: synchronous write, asynchronous read onto a shared tri-state data bus.
// Asynchronous active-low reset clears every word.
module sp_ram_bidir
  import sp_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] data,
  sp_ram_bidir_if.slave     bus
);

  word_t r_mem [DEPTH];
  op_e   w_op;
  logic  w_wr_en;
  logic  w_rd_oe;
  word_t w_rd_data;

  // Decode the operation; the illegal pair behaves as idle so the bus never sees contention
  always_comb begin
    w_op    = decode_op(bus.we, bus.enable);
    w_wr_en = 1'b0;
    w_rd_oe = 1'b0;
    case (w_op)
      WRITE:   w_wr_en = 1'b1;
      READ:    w_rd_oe = rst_n;
      IDLE:    w_rd_oe = 1'b0;
      ILLEGAL: w_rd_oe = 1'b0;
      default: w_rd_oe = 1'b0;
    endcase
  end

  assign w_rd_data = r_mem[bus.addr];

  // Storage array: cleared asynchronously, written on the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_en) begin
      r_mem[bus.addr] <= data;
    end
  end

  sp_ram_tribuf u_tribuf (
    .i_data (w_rd_data),
    .i_oe   (w_rd_oe),
    .io_pad (data)
  );

endmodule

// File: tb/tb_sp_ram_bidir.sv
// Self-checking bench for sp_ram_bidir: directed scenarios plus randomized traffic
// against an array model. The bus is pulled up, so an undriven bus reads 8'hFF.
module tb_sp_ram_bidir;
  import sp_ram_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       tb_oe;
  logic [7:0] tb_drv;
  tri1  [7:0] data;

  int errors;
  int checks;
  logic [7:0] exp_mem [16];

  sp_ram_bidir_if bus ();

  assign data = tb_oe ? tb_drv : 8'hzz;

  sp_ram_bidir dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ctrl(input logic we, input logic en, input int a, input logic oe, input logic [7:0] v);
    bus.we     = we;
    bus.enable = en;
    bus.addr   = 4'(a);
    tb_oe      = oe;
    tb_drv     = v;
  endtask

  task automatic do_write(input int a, input logic [7:0] v);
    @(negedge clk);
    set_ctrl(1'b1, 1'b0, a, 1'b1, v);
    @(posedge clk);
    if (rst_n) exp_mem[a] = v;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    set_ctrl(1'b0, 1'b0, 0, 1'b0, 8'h00);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    clear_model();
    set_ctrl(1'b0, 1'b1, 3, 1'b0, 8'h00);
    #1;
    checks++;
    if (data !== 8'hFF) begin
      $display("FAIL reset_hiz_read: got %h want ff (hi-z)", data);
      errors++;
    end
    @(negedge clk);
    set_ctrl(1'b1, 1'b0, 5, 1'b1, 8'h77);
    @(negedge clk);
    set_ctrl(1'b0, 1'b1, 0, 1'b0, 8'h00);
    #1;
    checks++;
    if (data !== 8'hFF) begin
      $display("FAIL reset_hiz_late: got %h want ff (hi-z)", data);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_ctrl(1'b0, 1'b1, i, 1'b0, 8'h00);
      #1;
      checks++;
      if (data !== 8'h00) begin
        $display("FAIL reset_clear addr=%0d: got %h want 00", i, data);
        errors++;
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) do_write(i, 8'(i));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_ctrl(1'b0, 1'b1, i, 1'b0, 8'h00);
      #1;
      checks++;
      if (data !== 8'(i)) begin
        $display("FAIL fill_read addr=%0d: got %h want %h", i, data, 8'(i));
        errors++;
      end
    end
  endtask

  task automatic test_overwrite();
    logic [7:0] want [3];
    do_write(3, 8'hA5);
    do_write(3, 8'h5A);
    want[0] = 8'h02;
    want[1] = 8'h5A;
    want[2] = 8'h04;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_ctrl(1'b0, 1'b1, 2 + k, 1'b0, 8'h00);
      #1;
      checks++;
      if (data !== want[k]) begin
        $display("FAIL overwrite addr=%0d: got %h want %h", 2 + k, data, want[k]);
        errors++;
      end
    end
  endtask

  task automatic test_idle_illegal();
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      set_ctrl(m[0], m[0], 7, 1'b1, 8'hFF);
      #1;
      checks++;
      if (data !== 8'hFF) begin
        $display("FAIL idle_contention mode=%0d: got %h want ff", m, data);
        errors++;
      end
      @(posedge clk);
      #1 tb_oe = 1'b0;
      #1;
      checks++;
      if (data !== 8'hFF) begin
        $display("FAIL idle_hiz mode=%0d: got %h want ff (hi-z)", m, data);
        errors++;
      end
      @(negedge clk);
      set_ctrl(1'b0, 1'b1, 7, 1'b0, 8'h00);
      #1;
      checks++;
      if (data !== exp_mem[7]) begin
        $display("FAIL idle_hold mode=%0d: got %h want %h", m, data, exp_mem[7]);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_ctrl(1'b0, 1'b1, 9, 1'b0, 8'h00);
      #1;
      checks++;
      if (data !== exp_mem[9]) begin
        $display("FAIL turnaround_read9: got %h want %h", data, exp_mem[9]);
        errors++;
      end
      do_write(10, 8'h3C);
    end
    @(negedge clk);
    set_ctrl(1'b0, 1'b1, 10, 1'b0, 8'h00);
    #1;
    checks++;
    if (data !== 8'h3C) begin
      $display("FAIL turnaround_read10: got %h want 3c", data);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_ctrl(1'b0, 1'b1, 15, 1'b0, 8'h00);
    #1;
    checks++;
    if (data !== exp_mem[15]) begin
      $display("FAIL async_pre addr=15: got %h want %h", data, exp_mem[15]);
      errors++;
    end
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if (data !== 8'hFF) begin
      $display("FAIL async_hiz: got %h want ff (hi-z)", data);
      errors++;
    end
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (data !== 8'h00) begin
      $display("FAIL async_clear addr=15: got %h want 00", data);
      errors++;
    end
    bus.addr = 4'd10;
    #1;
    checks++;
    if (data !== 8'h00) begin
      $display("FAIL async_clear addr=10: got %h want 00", data);
      errors++;
    end
  endtask

  task automatic test_random();
    int op;
    int a;
    logic [7:0] v;
    for (int n = 0; n < 120; n++) begin
      op = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 15));
      v  = 8'($urandom);
      if (op == 2) begin
        do_write(a, v);
      end else begin
        @(negedge clk);
        set_ctrl(op[1], op[0], a, 1'b0, 8'h00);
        #1;
        checks++;
        if (op == 1) begin
          if (data !== exp_mem[a]) begin
            $display("FAIL rand_read n=%0d addr=%0d: got %h want %h", n, a, data, exp_mem[a]);
            errors++;
          end
          a = (a + 1) % 16;
          bus.addr = 4'(a);
          #1;
          checks++;
          if (data !== exp_mem[a]) begin
            $display("FAIL rand_addr_track n=%0d addr=%0d: got %h want %h", n, a, data, exp_mem[a]);
            errors++;
          end
        end else if (data !== 8'hFF) begin
          $display("FAIL rand_hiz n=%0d op=%0d: got %h want ff (hi-z)", n, op, data);
          errors++;
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    tb_oe  = 1'b0;
    tb_drv = 8'h00;
    test_reset();
    test_fill();
    test_overwrite();
    test_idle_illegal();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
